// File: rtl/stage_sequencer.sv
// Multi-stage launch sequencer: arms, burns, separates and coasts through each
// configured stage, driving the engine velocity block's reset and configuration.
module stage_sequencer #(
    parameter int NUM_STAGES   = 3,
    parameter int SEP_CYCLES   = 10,
    parameter int COAST_CYCLES = 100
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        launch,
    input  logic        abort,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_idx,
    input  logic [63:0] cfg_prop,
    input  logic [63:0] cfg_dry,
    input  logic [63:0] cfg_isp,
    input  logic [63:0] payload,
    input  logic        ignition_end,
    output logic        eng_resetb,
    output logic [63:0] eng_initialWeight,
    output logic [63:0] eng_propellantWeight,
    output logic [63:0] eng_specificImpulse,
    output logic [1:0]  stage_idx,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_BURN, S_SEPARATE, S_COAST, S_DONE, S_ABORT
    } state_t;

    localparam logic [2:0]  NUM_STAGES_W = 3'(NUM_STAGES);
    localparam logic [1:0]  LAST_STAGE   = 2'(NUM_STAGES - 1);
    localparam logic [31:0] SEP_LAST     = (SEP_CYCLES <= 1) ? 32'd0 : 32'(SEP_CYCLES - 1);
    localparam logic [31:0] COAST_LAST   = (COAST_CYCLES <= 1) ? 32'd0 : 32'(COAST_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg;
    logic        first_burn_reg;
    logic [63:0] total_mass_reg;
    logic [1:0]  stage_reg;
    logic        aborted_reg;
    logic [63:0] eng_iw_reg, eng_pw_reg, eng_isp_reg;
    logic [63:0] stack_mass;
    logic        cfg_wr;

    // Table is always four entries deep so a 2-bit stage index selects it cleanly;
    // entries at or above NUM_STAGES are never written and stay zero.
    logic [63:0] prop_tab [4];
    logic [63:0] dry_tab  [4];
    logic [63:0] isp_tab  [4];

    assign cfg_wr = (state_reg == S_IDLE) && cfg_we && ({1'b0, cfg_idx} < NUM_STAGES_W);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cfg
            logic [63:0] prop_reg, dry_reg, isp_reg;
            always_ff @(posedge clk) begin
                if (resetb) begin
                    prop_reg <= '0;
                    dry_reg  <= '0;
                    isp_reg  <= '0;
                end else if (cfg_wr && cfg_idx == 2'(gi)) begin
                    prop_reg <= cfg_prop;
                    dry_reg  <= cfg_dry;
                    isp_reg  <= cfg_isp;
                end
            end
            assign prop_tab[gi] = prop_reg;
            assign dry_tab[gi]  = dry_reg;
            assign isp_tab[gi]  = isp_reg;
        end
    endgenerate

    always_comb begin
        stack_mass = payload;
        for (int i = 0; i < 4; i++) begin
            if (i < NUM_STAGES) stack_mass = stack_mass + prop_tab[i] + dry_tab[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (launch) state_next = S_ARM;
            S_ARM:      state_next = abort ? S_ABORT : S_BURN;
            S_BURN: begin
                if (abort)                                state_next = S_ABORT;
                else if (ignition_end && !first_burn_reg) state_next = S_SEPARATE;
            end
            S_SEPARATE: begin
                if (abort)                    state_next = S_ABORT;
                else if (cnt_reg == SEP_LAST) state_next = (stage_reg == LAST_STAGE) ? S_DONE : S_COAST;
            end
            S_COAST: begin
                if (abort)                      state_next = S_ABORT;
                else if (cnt_reg == COAST_LAST) state_next = S_ARM;
            end
            S_DONE:     state_next = S_DONE;
            S_ABORT:    state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            first_burn_reg <= 1'b0;
            total_mass_reg <= '0;
            stage_reg      <= '0;
            aborted_reg    <= 1'b0;
            eng_iw_reg     <= '0;
            eng_pw_reg     <= '0;
            eng_isp_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            first_burn_reg <= (state_reg == S_ARM);
            if (state_next == state_reg && (state_reg == S_SEPARATE || state_reg == S_COAST))
                cnt_reg <= cnt_reg + 32'd1;
            else
                cnt_reg <= '0;
            case (state_reg)
                S_IDLE: if (launch) begin
                    stage_reg      <= '0;
                    total_mass_reg <= stack_mass;
                    aborted_reg    <= 1'b0;
                end
                S_ARM: begin
                    eng_iw_reg  <= total_mass_reg;
                    eng_pw_reg  <= prop_tab[stage_reg];
                    eng_isp_reg <= isp_tab[stage_reg];
                end
                S_BURN: if (state_next == S_SEPARATE)
                    total_mass_reg <= total_mass_reg - prop_tab[stage_reg] - dry_tab[stage_reg];
                S_SEPARATE: if (state_next == S_COAST)
                    stage_reg <= stage_reg + 2'd1;
                default: ;
            endcase
            if (state_next == S_ABORT) aborted_reg <= 1'b1;
        end
    end

    assign eng_resetb           = (state_reg == S_BURN);
    assign busy                 = (state_reg == S_ARM) || (state_reg == S_BURN) ||
                                  (state_reg == S_SEPARATE) || (state_reg == S_COAST);
    assign done                 = (state_reg == S_DONE);
    assign aborted              = aborted_reg;
    assign stage_idx            = stage_reg;
    assign eng_initialWeight    = eng_iw_reg;
    assign eng_propellantWeight = eng_pw_reg;
    assign eng_specificImpulse  = eng_isp_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed flights with a scoreboard of expected
// burn/done/abort events checked by an independent monitor.
module tb_stage_sequencer;

    localparam int NS = 2;
    localparam int SEP = 3;
    localparam int COAST = 5;

    logic        clk = 1'b0;
    logic        resetb = 1'b1;
    logic        launch = 1'b0, abort = 1'b0, cfg_we = 1'b0, ignition_end = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [63:0] cfg_prop = '0, cfg_dry = '0, cfg_isp = '0, payload = '0;
    logic        eng_resetb, busy, done, aborted;
    logic [63:0] eng_initialWeight, eng_propellantWeight, eng_specificImpulse;
    logic [1:0]  stage_idx;

    stage_sequencer #(.NUM_STAGES(NS), .SEP_CYCLES(SEP), .COAST_CYCLES(COAST)) dut (
        .clk(clk), .resetb(resetb), .launch(launch), .abort(abort),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_prop(cfg_prop), .cfg_dry(cfg_dry),
        .cfg_isp(cfg_isp), .payload(payload), .ignition_end(ignition_end),
        .eng_resetb(eng_resetb), .eng_initialWeight(eng_initialWeight),
        .eng_propellantWeight(eng_propellantWeight), .eng_specificImpulse(eng_specificImpulse),
        .stage_idx(stage_idx), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    localparam int EV_BURN = 0, EV_DONE = 1, EV_ABORT = 2;
    typedef struct {
        int          kind;
        logic [1:0]  stg;
        logic [63:0] iw, pw, isp;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int kind, input logic [1:0] stg, input logic [63:0] iw,
                        input logic [63:0] pw, input logic [63:0] isp);
        ev_t e;
        e.kind = kind; e.stg = stg; e.iw = iw; e.pw = pw; e.isp = isp;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [63:0] p, input logic [63:0] d,
                             input logic [63:0] i);
        cfg_we = 1'b1; cfg_idx = idx; cfg_prop = p; cfg_dry = d; cfg_isp = i;
        tick();
        cfg_we = 1'b0;
        $display("cfg write idx=%0d prop=%0d dry=%0d isp=%0d", idx, p, d, i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_aborted"}, 64'(aborted), 64'd0);
        check({tag, "_eng_resetb"}, 64'(eng_resetb), 64'd0);
        check({tag, "_stage_idx"}, 64'(stage_idx), 64'd0);
        check({tag, "_eng_iw"}, eng_initialWeight, 64'd0);
        check({tag, "_eng_pw"}, eng_propellantWeight, 64'd0);
        check({tag, "_eng_isp"}, eng_specificImpulse, 64'd0);
    endtask

    // Monitor: every rising edge of eng_resetb, done or aborted is a DUT event.
    initial begin
        logic prev_er, prev_done, prev_ab;
        ev_t  e;
        int   kind;
        prev_er = 1'b0; prev_done = 1'b0; prev_ab = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                kind = -1;
                if (eng_resetb && !prev_er) kind = EV_BURN;
                else if (done && !prev_done) kind = EV_DONE;
                else if (aborted && !prev_ab) kind = EV_ABORT;
                if (kind >= 0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_event: got kind %0d, expected none", kind);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", 64'(kind), 64'(e.kind));
                        check("event_stage", 64'(stage_idx), 64'(e.stg));
                        if (e.kind == EV_BURN) begin
                            check("burn_initialWeight", eng_initialWeight, e.iw);
                            check("burn_propellantWeight", eng_propellantWeight, e.pw);
                            check("burn_specificImpulse", eng_specificImpulse, e.isp);
                        end
                        $display("event kind=%0d stage=%0d iw=%0d pw=%0d isp=%0d",
                                 kind, stage_idx, eng_initialWeight, eng_propellantWeight,
                                 eng_specificImpulse);
                    end
                end
            end
            prev_er = eng_resetb; prev_done = done; prev_ab = aborted;
        end
    end

    initial begin
        int n;

        // Reset state.
        resetb = 1'b1;
        tick(); tick();
        resetb = 1'b0;
        check_reset_outputs("reset");

        // Flight 1: two stages, nominal to DONE; idx 2 write is out of range.
        payload = 64'd100;
        cfg_write(2'd0, 64'd500, 64'd50, 64'd300);
        cfg_write(2'd1, 64'd200, 64'd20, 64'd350);
        cfg_write(2'd2, 64'd9999, 64'd9999, 64'd9999);
        push(EV_BURN, 2'd0, 64'd870, 64'd500, 64'd300);
        push(EV_BURN, 2'd1, 64'd320, 64'd200, 64'd350);
        push(EV_DONE, 2'd1, 64'd0, 64'd0, 64'd0);

        launch = 1'b1; tick(); launch = 1'b0;
        check("arm_busy", 64'(busy), 64'd1);
        check("arm_eng_resetb", 64'(eng_resetb), 64'd0);
        tick();
        check("burn0_eng_resetb", 64'(eng_resetb), 64'd1);
        tick(); tick();
        ignition_end = 1'b1; tick(); ignition_end = 1'b0;
        check("sep0_eng_resetb", 64'(eng_resetb), 64'd0);
        check("sep0_busy", 64'(busy), 64'd1);
        tick(); tick(); tick();
        check("coast_stage_idx", 64'(stage_idx), 64'd1);
        cfg_write(2'd1, 64'd7, 64'd7, 64'd7);
        n = 0;
        while (!eng_resetb && n < 100) begin tick(); n++; end
        check("coast_to_burn_cycles", 64'(n), 64'd5);

        // ignition_end held high: first BURN cycle ignored.
        ignition_end = 1'b1;
        tick();
        check("held_ign_first_cycle_burn", 64'(eng_resetb), 64'd1);
        tick();
        check("held_ign_second_cycle_sep", 64'(eng_resetb), 64'd0);
        ignition_end = 1'b0;
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        check("sep_to_done_cycles", 64'(n), 64'(SEP));
        check("done_busy", 64'(busy), 64'd0);
        check("done_eng_resetb", 64'(eng_resetb), 64'd0);
        launch = 1'b1; tick(); launch = 1'b0;
        check("done_ignores_launch", 64'(done), 64'd1);

        // Flight 2: abort in BURN, relaunch clears aborted.
        resetb = 1'b1; tick(); resetb = 1'b0;
        check_reset_outputs("reset_from_done");
        cfg_write(2'd0, 64'd500, 64'd50, 64'd300);
        cfg_write(2'd1, 64'd200, 64'd20, 64'd350);
        push(EV_BURN, 2'd0, 64'd870, 64'd500, 64'd300);
        push(EV_ABORT, 2'd0, 64'd0, 64'd0, 64'd0);
        launch = 1'b1; tick(); launch = 1'b0;
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_aborted", 64'(aborted), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_eng_resetb", 64'(eng_resetb), 64'd0);
        tick();
        check("idle_after_abort_aborted", 64'(aborted), 64'd1);
        check("idle_after_abort_busy", 64'(busy), 64'd0);
        push(EV_BURN, 2'd0, 64'd870, 64'd500, 64'd300);
        launch = 1'b1; tick(); launch = 1'b0;
        check("relaunch_clears_aborted", 64'(aborted), 64'd0);
        tick(); tick();
        ignition_end = 1'b1; tick(); ignition_end = 1'b0;
        tick(); tick(); tick();
        check("coast1_stage_idx", 64'(stage_idx), 64'd1);
        tick();

        // Reset mid-COAST of stage 1; table must be zeroed.
        resetb = 1'b1; tick(); resetb = 1'b0;
        check_reset_outputs("reset_mid_coast");
        push(EV_BURN, 2'd0, 64'd100, 64'd0, 64'd0);
        push(EV_ABORT, 2'd0, 64'd0, 64'd0, 64'd0);
        launch = 1'b1; tick(); launch = 1'b0;
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        tick(); tick(); tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
